// File: rtl/otter_pipe_hazard_ctrl.sv
// otter_pipe_hazard_ctrl
//   Hazard and forwarding controller for the OTTER pipelined MCU.
//   Keeps a scoreboard of in-flight destination registers (entry 0 = ID/EX,
//   entry 1 = EX/MEM, ...). From it the block derives the load-use stall,
//   the redirect flush and the EX-stage operand forwarding selects.
//
// Parameters
//   DEPTH     scoreboard entries after ID (2..6)
//   LOAD_LAT  extra cycles after EX before load data can be forwarded (1..DEPTH-1)
//   RA_W      register-address width
//   SEL_W     forwarding-select width (holds 0..DEPTH-1)
//
// Ports
//   CLOCK, RESET                 clock, synchronous active-high reset
//   ID_RS1/ID_RS2, ID_USE_RS*    sources of the IF/ID instruction
//   ID_RD, ID_REGWRITE, ID_MEMREAD  destination info of the IF/ID instruction
//   EX_REDIRECT                  taken branch/jump resolved in EX
//   EXT_STALL                    freeze the whole pipeline
//   PC_WRITE, IF_ID_WRITE        PC and IF/ID enables
//   IF_ID_FLUSH, ID_EX_BUBBLE    NOP insertion into IF/ID and ID/EX
//   FWD_SEL_A/B                  EX operand source: 0 = ID/EX, k = pipeline reg k
//   STALL_CNT, FLUSH_CNT         saturating load-use / redirect counters,
//                                present only when OTTER_HAZARD_PERF_EN is defined
module otter_pipe_hazard_ctrl #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned SEL_W    = 3
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [RA_W-1:0]  ID_RS1,
    input  logic [RA_W-1:0]  ID_RS2,
    input  logic             ID_USE_RS1,
    input  logic             ID_USE_RS2,
    input  logic [RA_W-1:0]  ID_RD,
    input  logic             ID_REGWRITE,
    input  logic             ID_MEMREAD,
    input  logic             EX_REDIRECT,
    input  logic             EXT_STALL,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
`ifdef OTTER_HAZARD_PERF_EN
    output logic [31:0]      STALL_CNT,
    output logic [31:0]      FLUSH_CNT,
`endif
    output logic [SEL_W-1:0] FWD_SEL_A,
    output logic [SEL_W-1:0] FWD_SEL_B
);

    logic [DEPTH-1:0]           v_q, v_d, rw_q, rw_d, mr_q, mr_d;
    logic [DEPTH-1:0][RA_W-1:0] rd_q, rd_d;
    logic [RA_W-1:0]            ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic                       ex_u1_q, ex_u1_d, ex_u2_q, ex_u2_d;

    logic [DEPTH-1:0] hit_id1, hit_id2, hit_ex1, hit_ex2;
    logic             load_use;
    logic [SEL_W:0]   pick_a, pick_b;

    // Youngest producer wins. MSB of the result flags a load that is still
    // too young to forward; the select then falls back to 0.
    function automatic logic [SEL_W:0] pick_src(input logic [DEPTH-1:0] hit,
                                                input logic [DEPTH-1:0] mr);
        logic [SEL_W:0] r;
        logic           found;
        r     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            if (!found && hit[k]) begin
                found = 1'b1;
                if (mr[k] && (k < LOAD_LAT + 1)) r[SEL_W] = 1'b1;
                else                             r[SEL_W-1:0] = SEL_W'(k);
            end
        end
        return r;
    endfunction

    always_comb begin
        hit_id1  = '0;
        hit_id2  = '0;
        hit_ex1  = '0;
        hit_ex2  = '0;
        load_use = 1'b0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            hit_id1[e] = v_q[e] && rw_q[e] && (rd_q[e] == ID_RS1)   && (ID_RS1   != '0) && ID_USE_RS1;
            hit_id2[e] = v_q[e] && rw_q[e] && (rd_q[e] == ID_RS2)   && (ID_RS2   != '0) && ID_USE_RS2;
            hit_ex1[e] = v_q[e] && rw_q[e] && (rd_q[e] == ex_rs1_q) && (ex_rs1_q != '0) && ex_u1_q;
            hit_ex2[e] = v_q[e] && rw_q[e] && (rd_q[e] == ex_rs2_q) && (ex_rs2_q != '0) && ex_u2_q;
        end
        for (int unsigned j = 0; j < LOAD_LAT; j++) begin
            if (mr_q[j] && (hit_id1[j] || hit_id2[j])) load_use = 1'b1;
        end
    end

    always_comb begin
        pick_a       = pick_src(hit_ex1, mr_q);
        pick_b       = pick_src(hit_ex2, mr_q);
        v_d          = v_q;
        rd_d         = rd_q;
        rw_d         = rw_q;
        mr_d         = mr_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_u1_d      = ex_u1_q;
        ex_u2_d      = ex_u2_q;
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        FWD_SEL_A    = pick_a[SEL_W-1:0];
        FWD_SEL_B    = pick_b[SEL_W-1:0];

        if (RESET) begin
            ID_EX_BUBBLE = 1'b1;
            FWD_SEL_A    = '0;
            FWD_SEL_B    = '0;
        end else if (EXT_STALL) begin
            PC_WRITE    = 1'b0;
            IF_ID_WRITE = 1'b0;
        end else begin
            for (int unsigned e = 1; e < DEPTH; e++) begin
                v_d[e]  = v_q[e-1];
                rd_d[e] = rd_q[e-1];
                rw_d[e] = rw_q[e-1];
                mr_d[e] = mr_q[e-1];
            end
            if (EX_REDIRECT || load_use) begin
                // The bubble entering ID/EX carries no sources, so the next
                // EX cycle never forwards on behalf of a squashed instruction.
                v_d[0]       = 1'b0;
                rw_d[0]      = 1'b0;
                mr_d[0]      = 1'b0;
                ex_u1_d      = 1'b0;
                ex_u2_d      = 1'b0;
                ID_EX_BUBBLE = 1'b1;
                if (EX_REDIRECT) begin
                    IF_ID_FLUSH = 1'b1;
                end else begin
                    PC_WRITE    = 1'b0;
                    IF_ID_WRITE = 1'b0;
                end
            end else begin
                v_d[0]   = 1'b1;
                rd_d[0]  = ID_RD;
                rw_d[0]  = ID_REGWRITE;
                mr_d[0]  = ID_MEMREAD;
                ex_rs1_d = ID_RS1;
                ex_rs2_d = ID_RS2;
                ex_u1_d  = ID_USE_RS1;
                ex_u2_d  = ID_USE_RS2;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            v_q      <= '0;
            rd_q     <= '0;
            rw_q     <= '0;
            mr_q     <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            ex_u1_q  <= 1'b0;
            ex_u2_q  <= 1'b0;
        end else begin
            v_q      <= v_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            ex_u1_q  <= ex_u1_d;
            ex_u2_q  <= ex_u2_d;
        end
        // A forwardable match on a too-young load means the stall logic let
        // a dependent instruction through.
        if (!RESET) assert (!(pick_a[SEL_W] || pick_b[SEL_W]));
    end

`ifdef OTTER_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!EXT_STALL) begin
            if (EX_REDIRECT) begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
            end else if (load_use) begin
                if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule
